psum_drain: RTL and testbench

Downstream companion to the MAC datapath. It tracks window boundaries through the MAC pipeline latency and snapshots the free-running MAC accumulator at each window end. It subtracts the previous snapshot to recover that window's dot product, then applies ReLU, a right shift and saturation. Results go into a small output FIFO with a valid/ready interface toward the activation writer.

---
 rtl/npu_pkg.sv | 6 +
 rtl/psum_fifo.sv | 41 ++++
 rtl/psum_drain.sv | 59 +++++
 tb/tb_psum_drain.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU constants so the MAC and the drain agree on widths and latency
package npu_pkg;
   localparam int NPU_WIDTH   = 16;
   localparam int NPU_OUT_W   = 8;
   localparam int NPU_MAC_LAT = 3;
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: synchronous show-ahead FIFO; data reads 0 while empty
module psum_fifo import npu_pkg::*; #(
   parameter int W     = NPU_OUT_W,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;
   assign empty   = cnt == '0;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rp];
   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
   // pointers wrap modulo DEPTH; the extra count bit separates full from empty
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wp + AW'(do_push);
         rp  <= rp + AW'(do_pop);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/psum_drain.sv
// psum_drain: per-window dot product from MAC snapshots, ReLU/shift/saturate, output FIFO
module psum_drain import npu_pkg::*; #(
   parameter int WIDTH   = NPU_WIDTH,
   parameter int OUT_W   = NPU_OUT_W,
   parameter int MAC_LAT = NPU_MAC_LAT,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic                       tag_valid,
   input  logic                       tag_last,
   input  logic signed [WIDTH-1:0]    mac_out,
   input  logic                       relu_en,
   input  logic [$clog2(WIDTH)-1:0]   shift,
   output logic signed [OUT_W-1:0]    out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       overflow
);
   localparam logic signed [WIDTH-1:0] SAT_HI = WIDTH'(2**(OUT_W-1)-1);
   localparam logic signed [WIDTH-1:0] SAT_LO = ~SAT_HI;
   logic [MAC_LAT-1:0]       tag_pipe;
   logic                     cap, full, empty;
   logic signed [WIDTH-1:0]  base, diff, r_shift, r_relu;
   logic [OUT_W-1:0]         res, head;
   assign cap       = tag_pipe[MAC_LAT-1];
   assign diff      = mac_out - base;
   assign r_shift   = diff >>> shift;
   assign out_valid = !empty;
   assign out_data  = head;
   // ReLU then clamp into the signed OUT_W range
   always_comb begin
      r_relu = (relu_en && r_shift[WIDTH-1]) ? '0 : r_shift;
      res    = (r_relu > SAT_HI) ? SAT_HI[OUT_W-1:0] :
               (r_relu < SAT_LO) ? SAT_LO[OUT_W-1:0] : r_relu[OUT_W-1:0];
   end
   // tag delay line, snapshot base and sticky drop flag
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         tag_pipe <= '0;
         base     <= '0;
         overflow <= 1'b0;
      end else begin
         tag_pipe <= (tag_pipe << 1) | MAC_LAT'(tag_valid & tag_last);
         if (cap) base <= mac_out;
         if (cap && full && !out_ready) overflow <= 1'b1;
      end
   end
   psum_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (cap),
      .pop   (out_ready),
      .din   (res),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed and random windows against a window-level reference model
module tb_psum_drain;
   import npu_pkg::*;
   localparam int W = NPU_WIDTH, OW = NPU_OUT_W, DEPTH = 4;
   logic clk = 0, rstb = 0, tag_valid = 0, tag_last = 0, relu_en = 0, out_ready = 0;
   logic [$clog2(W)-1:0] shift = '0;
   logic signed [W-1:0] a = '0, b = '0, mac_out, mp0, mp1;
   logic signed [OW-1:0] out_data;
   logic out_valid, overflow;
   int errors = 0, checks = 0;
   logic signed [OW-1:0] mq[$];
   bit movf = 0;
   int pa[$], pb[$], wsum[$];

   always #5 clk = ~clk;

   // MAC stand-in: product sampled at the first edge appears in mac_out after the third
   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         mp0 <= '0; mp1 <= '0; mac_out <= '0;
      end else begin
         mp0 <= tag_valid ? a * b : '0;
         mp1 <= mp0;
         mac_out <= mac_out + mp1;
      end
   end

   psum_drain dut (
      .clk(clk), .rstb(rstb), .tag_valid(tag_valid), .tag_last(tag_last),
      .mac_out(mac_out), .relu_en(relu_en), .shift(shift), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [OW-1:0] ref_res(input int sum);
      logic signed [W-1:0] w;
      int r;
      w = W'(sum);
      r = int'(w) >>> int'(shift);
      if (relu_en && r < 0) r = 0;
      if (r > 2**(OW-1)-1) r = 2**(OW-1)-1;
      if (r < -(2**(OW-1))) r = -(2**(OW-1));
      return OW'(r);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pair(input int x, input int y);
      pa.push_back(x);
      pb.push_back(y);
   endtask

   task automatic send;
      int s = 0;
      int n = pa.size();
      for (int i = 0; i < n; i++) begin
         a = W'(pa[i]); b = W'(pb[i]);
         s += pa[i] * pb[i];
         tag_valid = 1; tag_last = (i == n - 1);
         tick;
      end
      a = '0; b = '0; tag_valid = 0; tag_last = 0;
      pa.delete(); pb.delete();
      wsum.push_back(s);
   endtask

   task automatic flush;
      while (wsum.size() != 0) begin
         logic signed [OW-1:0] v;
         v = ref_res(wsum.pop_front());
         if (mq.size() < DEPTH) mq.push_back(v);
         else movf = 1;
      end
   endtask

   task automatic settle;
      repeat (NPU_MAC_LAT) tick;
      flush;
   endtask

   task automatic pop_chk(input string tag);
      chk({tag, "_valid"}, out_valid, mq.size() != 0);
      chk({tag, "_data"}, out_data, mq.size() != 0 ? mq[0] : 0);
      out_ready = 1;
      tick;
      out_ready = 0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tick; tick;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ovf", overflow, 0);
      rstb = 1;
      tick;
      // accumulator wrap: 30000 then 5000 pushes mac_out past +32767
      shift = 0; relu_en = 1;
      pair(100, 300); send; settle;
      chk("wrap1_const", out_data, 127);
      pop_chk("wrap1");
      shift = 6;
      pair(50, 100); send; settle;
      chk("wrap2_const", out_data, 78);
      pop_chk("wrap2");
      // basic window with latency check
      shift = 0; relu_en = 1;
      pair(2, 3); pair(4, 5); pair(-1, 6); send;
      tick; chk("lat_e1", out_valid, 0);
      tick; chk("lat_e2", out_valid, 0);
      tick; chk("lat_e3", out_valid, 1);
      flush;
      chk("basic_const", out_data, 20);
      pop_chk("basic");
      // saturate and shift
      pair(10, 10); pair(10, 10); send; settle;
      chk("sat_const", out_data, 127);
      pop_chk("sat");
      shift = 1;
      pair(10, 10); pair(10, 10); send; settle;
      chk("shift_const", out_data, 100);
      pop_chk("shift");
      // ReLU and base tracking
      shift = 0; relu_en = 0;
      pair(-3, 4); send; settle;
      chk("neg_const", out_data, -12);
      pop_chk("neg");
      relu_en = 1;
      pair(-3, 4); send; settle;
      chk("relu_const", out_data, 0);
      pop_chk("relu");
      pair(1, 1); send; settle;
      chk("base_const", out_data, 1);
      pop_chk("base");
      // push and pop on the same edge while full
      for (int k = 1; k <= 4; k++) begin
         pair(k, 1); send; settle;
      end
      chk("full_valid", out_valid, 1);
      pair(5, 1); send;
      tick; tick;
      out_ready = 1;
      tick;
      out_ready = 0;
      void'(mq.pop_front());
      flush;
      chk("pp_ovf", overflow, 0);
      chk("pp_head", out_data, 2);
      for (int k = 0; k < 4; k++) pop_chk("pp_drain");
      chk("pp_empty", out_valid, 0);
      // overflow on the fifth capture with the consumer stalled
      for (int k = 1; k <= 5; k++) begin
         pair(k, 1); send; settle;
      end
      chk("ovf_model", overflow, movf);
      chk("ovf_const", overflow, 1);
      for (int k = 1; k <= 4; k++) begin
         chk("ovf_drain_const", out_data, k);
         pop_chk("ovf_drain");
      end
      chk("ovf_empty", out_valid, 0);
      // random isolated windows
      repeat (12) begin
         int n;
         relu_en = 1'($urandom_range(0, 1));
         shift = 4'($urandom_range(0, 7));
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++)
            pair(int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60);
         send; settle;
         pop_chk("rand");
      end
      // random back-to-back windows
      repeat (3) begin
         relu_en = 1'($urandom_range(0, 1));
         shift = 4'($urandom_range(0, 4));
         for (int w = 0; w < 3; w++) begin
            int n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++)
               pair(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
            send;
         end
         settle;
         for (int w = 0; w < 3; w++) pop_chk("b2b");
         chk("b2b_empty", out_valid, 0);
      end
      // reset with two windows in flight and two entries queued
      relu_en = 1; shift = 0;
      pair(1, 2); send; pair(2, 2); send; settle;
      chk("pre_rst_valid", out_valid, 1);
      pair(1, 1); send; pair(1, 1); send;
      rstb = 0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ovf", overflow, 0);
      wsum.delete(); mq.delete(); movf = 0;
      tick; tick;
      rstb = 1;
      repeat (5) tick;
      chk("post_rst_valid", out_valid, 0);
      pair(3, 3); send; settle;
      chk("post_rst_const", out_data, 9);
      pop_chk("post_rst");
      chk("post_rst_empty", out_valid, 0);
      chk("post_rst_ovf", overflow, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
